// File: rtl/noc_pkg.sv
// Shared NoC router codes: output-port requests, arbiter input selects,
// flit types, head-flit field offsets and input-buffer FSM states.
package noc_pkg;

    localparam logic [2:0] REQ_L    = 3'b000;
    localparam logic [2:0] REQ_E    = 3'b001;
    localparam logic [2:0] REQ_W    = 3'b010;
    localparam logic [2:0] REQ_N    = 3'b011;
    localparam logic [2:0] REQ_S    = 3'b100;
    localparam logic [2:0] REQ_NONE = 3'b111;

    localparam logic [2:0] SEL_L = 3'd0;
    localparam logic [2:0] SEL_N = 3'd1;
    localparam logic [2:0] SEL_E = 3'd2;
    localparam logic [2:0] SEL_S = 3'd3;
    localparam logic [2:0] SEL_W = 3'd4;

    typedef enum logic [1:0] {
        FT_BODY     = 2'b00,
        FT_HEAD     = 2'b01,
        FT_TAIL     = 2'b10,
        FT_HEADTAIL = 2'b11
    } flit_type_e;

    localparam int HEAD_DEST_Y_LSB = 0;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } ibuf_state_e;

    function automatic int head_dest_x_lsb(int coord_w);
        return coord_w;
    endfunction

    function automatic logic is_head(logic [1:0] t);
        return (flit_type_e'(t) == FT_HEAD) ||
               (flit_type_e'(t) == FT_HEADTAIL);
    endfunction

    function automatic logic is_last(logic [1:0] t);
        return (flit_type_e'(t) == FT_TAIL) ||
               (flit_type_e'(t) == FT_HEADTAIL);
    endfunction

endpackage

// File: rtl/xy_route_calc.sv
// Combinational XY (dimension-order) route decode: X resolved first,
// then Y, local port when both coordinates match.
module xy_route_calc
    import noc_pkg::*;
#(
    parameter int COORD_W = 4,
    parameter int LOCAL_X = 0,
    parameter int LOCAL_Y = 0
) (
    input  logic [COORD_W-1:0] dest_x,
    input  logic [COORD_W-1:0] dest_y,
    output logic [2:0]         route
);

    localparam logic [COORD_W-1:0] LX = COORD_W'(LOCAL_X);
    localparam logic [COORD_W-1:0] LY = COORD_W'(LOCAL_Y);

    always_comb begin
        route = REQ_L;
        if (dest_x > LX) begin
            route = REQ_E;
        end else if (dest_x < LX) begin
            route = REQ_W;
        end else if (dest_y > LY) begin
            route = REQ_N;
        end else if (dest_y < LY) begin
            route = REQ_S;
        end
    end

endmodule

// File: rtl/input_route_buffer.sv
// Router input port: flit FIFO plus XY route FSM feeding the switch arbiter.
// Define NOC_IBUF_STATS_EN to add pkt_cnt / drop_cnt statistics outputs.
module input_route_buffer
    import noc_pkg::*;
#(
    parameter int FLIT_W     = 18,
    parameter int COORD_W    = 4,
    parameter int DEPTH      = 4,
    parameter int LOCAL_X    = 0,
    parameter int LOCAL_Y    = 0,
    parameter int N_REGISTER = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_W-1:0]     data_in,
    input  logic                  valid_in,
    output logic                  full,
    output logic [FLIT_W-1:0]     data_out,
    output logic [N_REGISTER-1:0] request,
    input  logic                  grant
`ifdef NOC_IBUF_STATS_EN
    ,
    output logic [15:0]           pkt_cnt,
    output logic [7:0]            drop_cnt
`endif
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DX_LSB = head_dest_x_lsb(COORD_W);

    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(DEPTH);
    localparam logic [N_REGISTER-1:0] RQ_NONE  = N_REGISTER'(REQ_NONE);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    ibuf_state_e           state;
    ibuf_state_e           state_n;
    logic [N_REGISTER-1:0] request_n;

    logic             empty;
    logic             push;
    logic             pop;
    logic             pop_pkt;
    logic             pop_last;
    logic             pop_stray;
    logic [1:0]       head_type;
    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
    logic [2:0]       route;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign push      = valid_in && !full;
    assign pop       = pop_pkt || pop_stray;
    assign data_out  = mem[rd_ptr];
    assign head_type = data_out[FLIT_W-1 -: 2];
    assign dest_x    = data_out[DX_LSB +: COORD_W];
    assign dest_y    = data_out[HEAD_DEST_Y_LSB +: COORD_W];

    xy_route_calc #(
        .COORD_W (COORD_W),
        .LOCAL_X (LOCAL_X),
        .LOCAL_Y (LOCAL_Y)
    ) u_route (
        .dest_x (dest_x),
        .dest_y (dest_y),
        .route  (route)
    );

    // Request only changes on head latch or tail pop, so the arbiter
    // sees one stable port for the whole packet.
    always_comb begin
        state_n   = state;
        request_n = request;
        pop_pkt   = 1'b0;
        pop_last  = 1'b0;
        pop_stray = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!empty) begin
                    if (is_head(head_type)) begin
                        request_n = N_REGISTER'(route);
                        state_n   = ST_ACTIVE;
                    end else begin
                        pop_stray = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                pop_pkt  = grant && !empty;
                pop_last = pop_pkt && is_last(head_type);
                if (pop_last) begin
                    request_n = RQ_NONE;
                    state_n   = ST_IDLE;
                end
            end
            default: begin
                state_n   = ST_IDLE;
                request_n = RQ_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            request <= RQ_NONE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            state   <= state_n;
            request <= request_n;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; contents are only read when count says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

`ifdef NOC_IBUF_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (pop_last && (pkt_cnt != '1)) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
            if (pop_stray && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_input_route_buffer.sv
// Self-checking bench for input_route_buffer at router (1,1).
// Route table vectors plus hand-written full/stray/reset sequences.
module tb_input_route_buffer;

    localparam int FW = 18;

    logic          clk;
    logic          rst;
    logic [FW-1:0] data_in;
    logic          valid_in;
    logic          full;
    logic [FW-1:0] data_out;
    logic [2:0]    request;
    logic          grant;
`ifdef NOC_IBUF_STATS_EN
    logic [15:0]   pkt_cnt;
    logic [7:0]    drop_cnt;
`endif

    input_route_buffer #(
        .FLIT_W     (FW),
        .COORD_W    (4),
        .DEPTH      (4),
        .LOCAL_X    (1),
        .LOCAL_Y    (1),
        .N_REGISTER (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .valid_in (valid_in),
        .full     (full),
        .data_out (data_out),
        .request  (request),
        .grant    (grant)
`ifdef NOC_IBUF_STATS_EN
        ,
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [2:0] req;
    } rvec_t;

    rvec_t         tbl [9];
    logic [FW-1:0] q [$];
    int            nchk;
    int            nerr;
    int            exp_pkt;
    int            exp_drop;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] mk(input logic [1:0] t,
                                         input logic [7:0] tag,
                                         input logic [3:0] x,
                                         input logic [3:0] y);
        return {t, tag, x, y};
    endfunction

    task automatic push_flit(input logic [FW-1:0] f);
        check("full_at_push", {31'd0, full}, {31'd0, q.size() == 4});
        data_in  = f;
        valid_in = 1'b1;
        if (q.size() < 4) q.push_back(f);
        cyc();
        valid_in = 1'b0;
        data_in  = '0;
    endtask

    task automatic pop_n(input int n);
        grant = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL pop_underflow: got empty expected flit");
            end else begin
                check("pop_data", {14'd0, data_out}, {14'd0, q[0]});
                if (q[0][FW-1]) exp_pkt++;
                cyc();
                void'(q.pop_front());
            end
        end
        grant = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        q.delete();
        exp_pkt  = 0;
        exp_drop = 0;
    endtask

    initial begin
        nchk = 0; nerr = 0; exp_pkt = 0; exp_drop = 0;
        rst = 1'b1; valid_in = 1'b0; data_in = '0; grant = 1'b0;
        tbl[0] = '{4'd3,  4'd1,  3'b001};
        tbl[1] = '{4'd0,  4'd1,  3'b010};
        tbl[2] = '{4'd1,  4'd3,  3'b011};
        tbl[3] = '{4'd1,  4'd0,  3'b100};
        tbl[4] = '{4'd1,  4'd1,  3'b000};
        tbl[5] = '{4'd0,  4'd0,  3'b010};
        tbl[6] = '{4'd2,  4'd0,  3'b001};
        tbl[7] = '{4'd15, 4'd15, 3'b001};
        tbl[8] = '{4'd1,  4'd15, 3'b011};

        cyc(); cyc();
        rst = 1'b0;
        check("reset_request", {29'd0, request}, 32'h7);
        check("reset_full", {31'd0, full}, 32'h0);
        cyc(); cyc(); cyc();
        check("idle_request", {29'd0, request}, 32'h7);
        check("idle_full", {31'd0, full}, 32'h0);
`ifdef NOC_IBUF_STATS_EN
        check("idle_drop_cnt", {24'd0, drop_cnt}, 32'h0);
`endif

        // Route table: one HEADTAIL per destination
        for (int i = 0; i < 9; i++) begin
            push_flit(mk(2'b11, 8'(8'h10 + i), tbl[i].x, tbl[i].y));
            check("route_latency", {29'd0, request}, 32'h7);
            cyc();
            check("route_req", {29'd0, request}, {29'd0, tbl[i].req});
            pop_n(1);
            check("route_release", {29'd0, request}, 32'h7);
        end

        // HEAD/BODY/TAIL held without grant, then drained
        push_flit(mk(2'b01, 8'hA0, 4'd1, 4'd1));
        push_flit(mk(2'b00, 8'hA1, 4'd5, 4'd6));
        push_flit(mk(2'b10, 8'hA2, 4'd7, 4'd8));
        for (int i = 0; i < 5; i++) cyc();
        check("hold_req", {29'd0, request}, 32'h0);
        check("hold_full", {31'd0, full}, 32'h0);
        pop_n(3);
        check("pkt_done_req", {29'd0, request}, 32'h7);

        // Fill to full, fifth flit refused, accepted on retry
        push_flit(mk(2'b01, 8'hB0, 4'd1, 4'd1));
        push_flit(mk(2'b00, 8'hB1, 4'd0, 4'd0));
        push_flit(mk(2'b00, 8'hB2, 4'd0, 4'd0));
        push_flit(mk(2'b00, 8'hB3, 4'd0, 4'd0));
        check("full_after_4", {31'd0, full}, 32'h1);
        push_flit(mk(2'b10, 8'hB4, 4'd0, 4'd0));
        check("full_still", {31'd0, full}, 32'h1);
        check("full_req", {29'd0, request}, 32'h0);
        pop_n(1);
        check("full_cleared", {31'd0, full}, 32'h0);
        push_flit(mk(2'b10, 8'hB4, 4'd0, 4'd0));
        check("full_refill", {31'd0, full}, 32'h1);
        pop_n(4);
        check("full_drain_req", {29'd0, request}, 32'h7);
        check("full_drain_full", {31'd0, full}, 32'h0);

        // Stray BODY at head in IDLE is discarded
        push_flit(mk(2'b00, 8'hC0, 4'd3, 4'd1));
        void'(q.pop_front());
        exp_drop++;
        check("stray_req", {29'd0, request}, 32'h7);
        cyc();
        check("stray_req_held", {29'd0, request}, 32'h7);
        check("stray_full", {31'd0, full}, 32'h0);
`ifdef NOC_IBUF_STATS_EN
        check("drop_cnt", {24'd0, drop_cnt}, exp_drop);
`endif
        push_flit(mk(2'b11, 8'hC1, 4'd3, 4'd1));
        cyc();
        check("post_stray_req", {29'd0, request}, 32'h1);
        pop_n(1);
        check("post_stray_rel", {29'd0, request}, 32'h7);
`ifdef NOC_IBUF_STATS_EN
        check("pkt_cnt", {16'd0, pkt_cnt}, exp_pkt);
`endif

        // Reset mid-packet
        push_flit(mk(2'b01, 8'hD0, 4'd0, 4'd2));
        cyc();
        check("mid_req_w", {29'd0, request}, 32'h2);
        pop_n(1);
        push_flit(mk(2'b00, 8'hD1, 4'd9, 4'd9));
        check("mid_req_held", {29'd0, request}, 32'h2);
        do_reset();
        check("rst_mid_req", {29'd0, request}, 32'h7);
        check("rst_mid_full", {31'd0, full}, 32'h0);
`ifdef NOC_IBUF_STATS_EN
        check("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'h0);
        check("rst_drop_cnt", {24'd0, drop_cnt}, 32'h0);
`endif
        push_flit(mk(2'b11, 8'hE0, 4'd1, 4'd0));
        check("post_rst_lat", {29'd0, request}, 32'h7);
        cyc();
        check("post_rst_req", {29'd0, request}, 32'h4);
        pop_n(1);
        check("post_rst_rel", {29'd0, request}, 32'h7);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
